// File: rtl/uart_rx_frame_ctrl.sv
// Checks SOF/LEN/payload/XOR frames from the UART byte stream and replays the buffered payload on valid/ready.
// valid_o rises 1 cycle after a matching checksum; data_o holds under !ready_i; bytes arriving during replay are dropped and flagged.
module uart_rx_frame_ctrl #(
  parameter int         MAX_LEN        = 16,
  parameter logic [7:0] SOF            = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] symbol_i,
  input  logic       newSymbol_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       last_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       err_o,
  output logic [1:0] errCode_o
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [LW-1:0] PTR_ONE   = LW'(1);
  localparam logic [TW-1:0] IDLE_ONE  = TW'(1);
  localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_OUT} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_buf [MAX_LEN];
  logic [LW-1:0] r_len;
  logic [LW-1:0] r_wr_ptr;
  logic [LW-1:0] r_rd_ptr;
  logic [7:0]    r_chk;
  logic [TW-1:0] r_idle;
  logic          r_err;
  logic [1:0]    r_err_code;

  logic       w_len_bad;
  logic       w_timeout;
  logic       w_last;
  logic       w_hs;
  logic       w_err_set;
  logic [1:0] w_err_code;

  assign w_len_bad = (symbol_i == 8'd0) || (symbol_i > MAX_LEN_B);
  // A strobe on the terminal idle cycle takes priority over the timeout.
  assign w_timeout = (r_idle == IDLE_LAST) && !newSymbol_i;
  assign w_last    = (r_rd_ptr == r_len - PTR_ONE);
  assign w_hs      = valid_o && ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (newSymbol_i && (symbol_i == SOF)) w_state_nxt = S_LEN;
      end
      S_LEN: begin
        if (newSymbol_i)    w_state_nxt = w_len_bad ? S_IDLE : S_PAYLOAD;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_PAYLOAD: begin
        if (newSymbol_i) begin
          if (r_wr_ptr == r_len - PTR_ONE) w_state_nxt = S_CHK;
        end else if (w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_CHK: begin
        if (newSymbol_i)    w_state_nxt = (symbol_i == r_chk) ? S_OUT : S_IDLE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_OUT: begin
        if (w_hs && w_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    valid_o    = (r_state == S_OUT);
    data_o     = valid_o ? r_buf[r_rd_ptr[AW-1:0]] : 8'd0;
    last_o     = valid_o && w_last;
    busy_o     = (r_state != S_IDLE);
    err_o      = r_err;
    errCode_o  = r_err_code;
    w_err_set  = 1'b0;
    w_err_code = 2'd0;
    case (r_state)
      S_LEN: begin
        if (newSymbol_i) begin
          if (w_len_bad) begin
            w_err_set  = 1'b1;
            w_err_code = 2'd1;
          end
        end else if (w_timeout) begin
          w_err_set  = 1'b1;
          w_err_code = 2'd3;
        end
      end
      S_PAYLOAD: begin
        if (w_timeout) begin
          w_err_set  = 1'b1;
          w_err_code = 2'd3;
        end
      end
      S_CHK: begin
        if (newSymbol_i) begin
          if (symbol_i != r_chk) begin
            w_err_set  = 1'b1;
            w_err_code = 2'd2;
          end
        end else if (w_timeout) begin
          w_err_set  = 1'b1;
          w_err_code = 2'd3;
        end
      end
      S_OUT: begin
        if (newSymbol_i) begin
          w_err_set  = 1'b1;
          w_err_code = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len      <= '0;
      r_chk      <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_idle     <= '0;
      r_err      <= 1'b0;
      r_err_code <= 2'd0;
    end else begin
      r_err <= w_err_set;
      if (w_err_set) r_err_code <= w_err_code;
      if (newSymbol_i || (w_state_nxt != r_state) || (r_state == S_IDLE) || (r_state == S_OUT))
        r_idle <= '0;
      else
        r_idle <= r_idle + IDLE_ONE;
      case (r_state)
        S_LEN: begin
          if (newSymbol_i) begin
            r_len    <= symbol_i[LW-1:0];
            r_chk    <= symbol_i;
            r_wr_ptr <= '0;
          end
        end
        S_PAYLOAD: begin
          if (newSymbol_i) begin
            r_chk    <= r_chk ^ symbol_i;
            r_wr_ptr <= r_wr_ptr + PTR_ONE;
          end
        end
        S_CHK: begin
          if (newSymbol_i) r_rd_ptr <= '0;
        end
        S_OUT: begin
          if (w_hs) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == S_PAYLOAD) && newSymbol_i) r_buf[r_wr_ptr[AW-1:0]] <= symbol_i;
  end

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream produced by the UART receive wrapper (symbol / newSymbol) into checked command frames.
- Frame format: SOF byte, LEN byte, LEN payload bytes, XOR checksum byte.
- Buffers one frame, validates it, then presents the payload to a downstream consumer over a valid/ready stream.
- Reports framing, length, checksum, timeout and overrun errors.

Parameters:
- MAX_LEN, 16: maximum payload length in bytes; buffer depth.
- SOF, 8'hA5: start-of-frame byte value.
- TIMEOUT_CYCLES, 10000: maximum idle clk cycles between bytes inside a frame.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- symbol_i  input  8  received byte from UART receive wrapper; valid only when newSymbol_i=1
- newSymbol_i  input  1  single-cycle strobe, new byte on symbol_i
- data_o  output  8  payload byte
- valid_o  output  1  data_o valid
- last_o  output  1  data_o is final payload byte of frame; qualified by valid_o
- ready_i  input  1  consumer accepts data_o when valid_o&&ready_i
- busy_o  output  1  high in any state except IDLE
- err_o  output  1  single-cycle error pulse
- errCode_o  output  2  1=bad length, 2=bad checksum, 3=overrun/timeout; held until next err_o

Behaviour:
- One clock: clk. Reset is asynchronous, active-high on rst. Reset forces all state and outputs: state=IDLE; data_o=0, valid_o=0, last_o=0, busy_o=0, err_o=0, errCode_o=0; counters and pointers cleared. Buffer contents are don't-care.
- States:
  - IDLE: on newSymbol_i with symbol_i==SOF go to LEN. Other bytes are silently discarded; no error.
  - LEN: on byte, latch len, chk=byte.
    - If byte==0 or byte>MAX_LEN: err_o, errCode=1, go to IDLE.
    - Otherwise go to PAYLOAD, wr_ptr=0.
  - PAYLOAD: on byte, buf[wr_ptr]=byte, chk^=byte, wr_ptr++. After the len-th byte go to CHK.
  - CHK: on byte.
    - If byte==chk: go to OUT, rd_ptr=0.
    - Otherwise: err_o, errCode=2, go to IDLE.
  - OUT: valid_o=1, data_o=buf[rd_ptr], last_o=(rd_ptr==len-1).
    - On valid_o&&ready_i: rd_ptr++.
    - On the handshake with last_o=1: go to IDLE; valid_o deasserts the next cycle.
- Registered outputs:
  - valid_o asserts the first cycle after entering OUT, i.e. 1 cycle after the checksum strobe.
  - data_o is stable while valid_o&&!ready_i.
  - Back-to-back transfers at 1 byte/cycle when ready_i stays high.
- Timeout: an idle counter runs in LEN, PAYLOAD and CHK, resets on every newSymbol_i, and clears on state entry. When it reaches TIMEOUT_CYCLES: err_o, errCode=3, go to IDLE. No timeout in IDLE or OUT.
- Overrun: newSymbol_i during OUT drops the byte and pulses err_o, errCode=3, once per dropped byte. The frame in progress continues unaffected.
- An SOF value seen mid-frame is treated as ordinary data; there is no resynchronisation.
- A byte strobe in the same cycle as the timeout terminal count: the byte wins and the counter clears.
- Checksum is XOR over LEN and all payload bytes, 8 bits.
- Reset mid-frame or mid-OUT: the frame is abandoned and valid_o drops immediately (asynchronous).
- err_o is high for exactly one cycle, registered. errCode_o updates in the same cycle as err_o.

Test Plan:
- Reset: rst=1 during traffic -> valid_o=0, busy_o=0, err_o=0, errCode_o=0 immediately; after release, non-SOF bytes 8'h11, 8'h22 -> no err_o, busy_o stays 0.
- Good frame: A5,03,10,20,30,chk=03^10^20^30=8'h03 with ready_i=1 -> data_o 10,20,30 on consecutive cycles; last_o only with 30; valid_o rises 1 cycle after chk strobe; busy_o falls after last handshake.
- Backpressure: same frame with ready_i toggling 0,0,1,0,1,1 -> each byte held stable while ready_i=0; exactly 3 handshakes, order preserved.
- Errors:
  - LEN=00 -> err_o pulse, errCode_o=1.
  - LEN=8'h11 (MAX_LEN=16) -> err_o pulse, errCode_o=1.
  - A5,02,AA,BB,chk=8'h00 (correct 8'h13) -> errCode_o=2, no valid_o.
- Timeout: A5,02,AA then silence for TIMEOUT_CYCLES -> err_o pulse, errCode_o=3, state IDLE; a following good frame is accepted. A gap of TIMEOUT_CYCLES-1 -> no error.
- Overrun: during OUT with ready_i=0, inject 2 bytes -> two err_o pulses, errCode_o=3; the original payload is then delivered intact.
